icache_direct: RTL and testbench

- Direct-mapped, one-word-per-line instruction cache.
- Sits between the instruction fetcher (upstream) and the memory controller's ICache port (downstream).
- Serves fetch requests from the tag/data arrays on a hit. On a miss it issues a single 4-byte fetch over the ic_mem_* handshake, fills the line and returns the instruction.
- Respects the pipeline flush (rob_clear) and the global rdy_in stall.

---
 rtl/icache_direct.sv | 196 +++++++++++++++++++
 tb/tb_icache_direct.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache.
//
// Sits between the instruction fetcher and the memory controller's ICache
// port. Hits are served from the tag/data arrays one cycle after the request
// edge. Misses issue a single word fetch over the ic_mem_* handshake, fill
// the line and return the instruction. Every access ends with a one-cycle
// WAIT bubble so the fetcher can advance its PC before the next lookup.
//
// Optional feature: define ICACHE_STAT_EN to add the hit_cnt/miss_cnt
// lookup statistics outputs.

module icache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        ic_valid,
    output logic [31:0] ic_inst,
    input  logic        rob_clear,
    output logic        ic_mem_ask,
    output logic [31:0] ic_mem_addr,
    input  logic        ic_mem_valid,
    input  logic [31:0] ic_mem_inst
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MISS,
        S_WAIT
    } state_e;

    // Control state and registered outputs
    state_e              state_q;
    logic                discard_q;
    logic                ic_valid_q;
    logic [31:0]         ic_inst_q;
    logic                ask_q;
    logic [31:0]         mem_addr_q;

    // Line storage: valid bits are reset, tag/data arrays are not
    logic [LINES-1:0]    line_valid_q;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    // Address split for the lookup (request) and the refill (miss address)
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  lookup_en;
    logic                  fill_en;

    assign req_index  = if_addr[INDEX_BITS+1:2];
    assign req_tag    = if_addr[31:INDEX_BITS+2];
    assign fill_index = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag   = mem_addr_q[31:INDEX_BITS+2];

    // Arrays are read combinationally; a hit needs a valid line with a matching tag
    assign hit = line_valid_q[req_index] && (tag_mem[req_index] == req_tag);

    // A lookup is accepted only from IDLE, outside a flush, with the pipeline enabled
    assign lookup_en = rdy_in && (state_q == S_IDLE) && !rob_clear && if_req;

    // Fill data is accepted only in MISS; stray ic_mem_valid pulses elsewhere are ignored
    assign fill_en = rdy_in && (state_q == S_MISS) && ic_mem_valid;

    // Instruction byte offset plays no part in a word-granular cache
    logic unused_addr_bits;
    assign unused_addr_bits = ^if_addr[1:0];

    // Control FSM with registered fetcher and memory-side outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            discard_q    <= 1'b0;
            ic_valid_q   <= 1'b0;
            ic_inst_q    <= 32'd0;
            ask_q        <= 1'b0;
            mem_addr_q   <= 32'd0;
            line_valid_q <= '0;
        end else if (rdy_in) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this block sees the pre-edge values of the others.
            case (state_q)
                S_IDLE: begin
                    ic_valid_q <= 1'b0;
                    if (lookup_en) begin
                        if (hit) begin
                            ic_inst_q  <= data_mem[req_index];
                            ic_valid_q <= 1'b1;
                            state_q    <= S_WAIT;
                        end else begin
                            ask_q      <= 1'b1;
                            mem_addr_q <= {if_addr[31:2], 2'b00};
                            discard_q  <= 1'b0;
                            state_q    <= S_MISS;
                        end
                    end
                end

                S_MISS: begin
                    if (ic_mem_valid) begin
                        // The line is filled even when the result is discarded
                        line_valid_q[fill_index] <= 1'b1;
                        ask_q                    <= 1'b0;
                        if (!discard_q && !rob_clear) begin
                            ic_inst_q  <= ic_mem_inst;
                            ic_valid_q <= 1'b1;
                            state_q    <= S_WAIT;
                        end else begin
                            ic_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (rob_clear) begin
                        // The controller transaction is never abandoned; only its result is
                        discard_q <= 1'b1;
                    end
                end

                S_WAIT: begin
                    ic_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end

                default: begin
                    ic_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    // Tag/data array write on refill
    always_ff @(posedge clk_in) begin
        // NOTE: the storage arrays carry no reset; line_valid_q alone decides
        // whether their contents mean anything, which keeps them RAM-mappable.
        if (fill_en) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= ic_mem_inst;
        end
    end

    assign ic_valid    = ic_valid_q;
    assign ic_inst     = ic_inst_q;
    assign ic_mem_ask  = ask_q;
    assign ic_mem_addr = mem_addr_q;

`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    // Next-count logic: each accepted lookup bumps exactly one counter, wrapping at 2^32
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_en) begin
            if (hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed self-checking bench for icache_direct.
// Covers reset, cold miss, hit with WAIT bubble, index conflict, flush during
// a miss, rdy_in stall mid-miss, flushed lookup, stray fill pulse and reset
// mid-miss. With ICACHE_STAT_EN defined it also checks the lookup counters.

module tb_icache_direct;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        rob_clear;
    logic        ic_mem_ask;
    logic [31:0] ic_mem_addr;
    logic        ic_mem_valid;
    logic [31:0] ic_mem_inst;
`ifdef ICACHE_STAT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    icache_direct #(.INDEX_BITS(6)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .ic_valid     (ic_valid),
        .ic_inst      (ic_inst),
        .rob_clear    (rob_clear),
        .ic_mem_ask   (ic_mem_ask),
        .ic_mem_addr  (ic_mem_addr),
        .ic_mem_valid (ic_mem_valid),
        .ic_mem_inst  (ic_mem_inst)
`ifdef ICACHE_STAT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STAT_EN
        check({tag, ".hit_cnt"}, hit_cnt, 32'(exp_hits));
        check({tag, ".miss_cnt"}, miss_cnt, 32'(exp_misses));
`else
        if (tag.len() == 0) $display("stats disabled");
`endif
    endtask

    // Miss with memory response four cycles after ask rises; expect delivery
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data, input string tag);
        if_req  = 1'b1;
        if_addr = addr;
        step();
        exp_misses++;
        check({tag, ".ask_rise"}, 32'(ic_mem_ask), 32'd1);
        check({tag, ".mem_addr"}, ic_mem_addr, {addr[31:2], 2'b00});
        check({tag, ".no_valid"}, 32'(ic_valid), 32'd0);
        if_addr = addr ^ 32'h0000_0F04;
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, ".ask_held"}, 32'(ic_mem_ask), 32'd1);
            check({tag, ".addr_held"}, ic_mem_addr, {addr[31:2], 2'b00});
        end
        if_addr      = addr;
        ic_mem_valid = 1'b1;
        ic_mem_inst  = data;
        step();
        ic_mem_valid = 1'b0;
        ic_mem_inst  = 32'd0;
        check({tag, ".valid"}, 32'(ic_valid), 32'd1);
        check({tag, ".inst"}, ic_inst, data);
        check({tag, ".ask_drop"}, 32'(ic_mem_ask), 32'd0);
        step();
        check({tag, ".bubble_valid"}, 32'(ic_valid), 32'd0);
        check({tag, ".bubble_ask"}, 32'(ic_mem_ask), 32'd0);
        if_req = 1'b0;
    endtask

    // Hit returns one cycle after the request edge, then a WAIT bubble with if_req still high
    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] data, input string tag);
        if_req  = 1'b1;
        if_addr = addr;
        step();
        exp_hits++;
        check({tag, ".valid"}, 32'(ic_valid), 32'd1);
        check({tag, ".inst"}, ic_inst, data);
        check({tag, ".no_ask"}, 32'(ic_mem_ask), 32'd0);
        step();
        check({tag, ".bubble_valid"}, 32'(ic_valid), 32'd0);
        check({tag, ".bubble_ask"}, 32'(ic_mem_ask), 32'd0);
        if_req = 1'b0;
    endtask

    initial begin
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        if_req       = 1'b0;
        if_addr      = 32'd0;
        rob_clear    = 1'b0;
        ic_mem_valid = 1'b0;
        ic_mem_inst  = 32'd0;

        // Reset state
        step();
        step();
        check("reset.valid", 32'(ic_valid), 32'd0);
        check("reset.inst", ic_inst, 32'd0);
        check("reset.ask", 32'(ic_mem_ask), 32'd0);
        check("reset.mem_addr", ic_mem_addr, 32'd0);
        check_stats("reset");
        rst_in = 1'b1;
        step();

        // Cold miss then hit
        fetch_miss(32'h0000_0000, 32'h0000_0013, "cold");
        fetch_hit(32'h0000_0000, 32'h0000_0013, "hit0");
        check_stats("after_hit0");

        // Index conflict: 0x100 evicts 0x000, which then misses again
        fetch_miss(32'h0000_0100, 32'h0010_0093, "conf100");
        fetch_miss(32'h0000_0000, 32'h0000_0013, "conf000");
        fetch_hit(32'h0000_0000, 32'h0000_0013, "conf_hit");

        // Flush during miss: fill happens, no delivery
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        step();
        exp_misses++;
        check("flush.ask_rise", 32'(ic_mem_ask), 32'd1);
        check("flush.mem_addr", ic_mem_addr, 32'h0000_0040);
        rob_clear = 1'b1;
        if_req    = 1'b0;
        step();
        rob_clear = 1'b0;
        check("flush.ask_held", 32'(ic_mem_ask), 32'd1);
        step();
        step();
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'hDEAD_BEEF;
        step();
        ic_mem_valid = 1'b0;
        check("flush.no_valid", 32'(ic_valid), 32'd0);
        check("flush.ask_drop", 32'(ic_mem_ask), 32'd0);
        step();
        check("flush.still_no_valid", 32'(ic_valid), 32'd0);
        fetch_hit(32'h0000_0040, 32'hDEAD_BEEF, "flush_hit");

        // Stall mid-miss: a fill presented while rdy_in=0 is not accepted
        if_req  = 1'b1;
        if_addr = 32'h0000_0080;
        step();
        exp_misses++;
        check("stall.ask_rise", 32'(ic_mem_ask), 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ic_mem_valid = (i == 2);
            ic_mem_inst  = 32'h1111_1111;
            step();
            check("stall.ask_held", 32'(ic_mem_ask), 32'd1);
            check("stall.no_valid", 32'(ic_valid), 32'd0);
            check("stall.addr_held", ic_mem_addr, 32'h0000_0080);
        end
        ic_mem_valid = 1'b0;
        rdy_in       = 1'b1;
        step();
        check("stall.still_miss", 32'(ic_mem_ask), 32'd1);
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h2222_2222;
        step();
        ic_mem_valid = 1'b0;
        check("stall.valid", 32'(ic_valid), 32'd1);
        check("stall.inst", ic_inst, 32'h2222_2222);
        check("stall.ask_drop", 32'(ic_mem_ask), 32'd0);
        if_req = 1'b0;
        step();
        check("stall.bubble", 32'(ic_valid), 32'd0);
        fetch_hit(32'h0000_0080, 32'h2222_2222, "stall_hit");

        // Lookup under rob_clear is ignored and counts as neither hit nor miss
        rob_clear = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0000;
        step();
        rob_clear = 1'b0;
        check("clr_idle.no_valid", 32'(ic_valid), 32'd0);
        check("clr_idle.no_ask", 32'(ic_mem_ask), 32'd0);
        fetch_hit(32'h0000_0000, 32'h0000_0013, "after_clr");

        // Stray fill pulse in IDLE is ignored
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h5555_5555;
        step();
        ic_mem_valid = 1'b0;
        check("stray.no_valid", 32'(ic_valid), 32'd0);
        check("stray.no_ask", 32'(ic_mem_ask), 32'd0);
        fetch_hit(32'h0000_0000, 32'h0000_0013, "stray_hit");
        check_stats("pre_reset");

        // Reset mid-miss clears valid bits and counters
        if_req  = 1'b1;
        if_addr = 32'h0000_00C0;
        step();
        check("rst_miss.ask_rise", 32'(ic_mem_ask), 32'd1);
        rst_in = 1'b0;
        if_req = 1'b0;
        #1;
        exp_hits   = 0;
        exp_misses = 0;
        check("rst_miss.ask", 32'(ic_mem_ask), 32'd0);
        check("rst_miss.mem_addr", ic_mem_addr, 32'd0);
        check("rst_miss.inst", ic_inst, 32'd0);
        check_stats("rst_miss");
        step();
        rst_in       = 1'b1;
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h7777_7777;
        step();
        ic_mem_valid = 1'b0;
        check("rst_stray.no_valid", 32'(ic_valid), 32'd0);
        check("rst_stray.no_ask", 32'(ic_mem_ask), 32'd0);
        fetch_miss(32'h0000_0000, 32'h0000_0013, "post_rst");
        fetch_hit(32'h0000_0000, 32'h0000_0013, "post_rst_hit");
        check_stats("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
